conv_1x1_weight_streamer: RTL
=============================

CONV_1X1_WEIGHT_STREAMER -- requirements
Module: conv_1x1_weight_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one weight word.
REQ-002 SHALL have parameter NUM_WEIGHTS, default 64, weights per pass.
REQ-003 SHALL have parameter ADDR_WIDTH, default 6, weight memory address width, at least clog2(NUM_WEIGHTS).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, capacity of the downstream weight buffer.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit, one-cycle request to begin a pass.
REQ-008 SHALL have port mem_rd_en, output, 1 bit, weight memory read strobe.
REQ-009 SHALL have port mem_addr, output, ADDR_WIDTH bits, weight memory address.
REQ-010 SHALL have port mem_data, input, DATA_WIDTH bits, read data, valid 1 cycle after mem_rd_en.
REQ-011 SHALL have port out, output, DATA_WIDTH bits, weight word toward the buffer.
REQ-012 SHALL have port valid_out, output, 1 bit, qualifies out for exactly one cycle per word.
REQ-013 SHALL have port load_weights, input, 1 bit, buffer read pulse; each pulse frees one slot.
REQ-014 SHALL have port busy, output, 1 bit, high outside IDLE.
REQ-015 SHALL have port done, output, 1 bit, one-cycle pulse when the last word of a pass is emitted.

Function
REQ-016 SHALL implement states IDLE, FETCH, DRAIN: IDLE->FETCH on start; FETCH->DRAIN after issuing read NUM_WEIGHTS-1; DRAIN->IDLE on the cycle the last valid_out is emitted.
REQ-017 SHALL ignore start while busy.
REQ-018 SHALL issue at most one read per cycle; addresses 0..NUM_WEIGHTS-1 in order, one per read.
REQ-019 SHALL register mem_data into out and delay mem_rd_en by two registers into valid_out, giving a 2-cycle mem_rd_en-to-valid_out latency.
REQ-020 SHALL keep a credit counter, 0..FIFO_DEPTH: +1 per issued read, -1 per load_weights; net 0 when both occur in one cycle.
REQ-021 SHALL issue a read only when the credit counter is below FIFO_DEPTH, so the buffer never overflows.
REQ-022 SHALL ignore load_weights while the counter is 0 (no underflow, no wrap).
REQ-023 SHALL track load_weights in every state, including IDLE, so credits persist across passes.
REQ-024 SHALL assert done together with the final valid_out of a pass.
REQ-025 SHALL hold out at its last value when valid_out is low.

Reset
REQ-026 SHALL, while reset is low, force state IDLE, mem_rd_en=0, mem_addr=0, out=0, valid_out=0, busy=0, done=0, credits=0.
REQ-027 SHALL abort a pass on mid-operation reset, discarding in-flight reads; no valid_out SHALL follow reset deassertion without a new start.

Configuration
REQ-028 SHALL, with WEIGHT_STREAMER_LOOP_EN defined, add input loop (1 bit); if loop is high when read NUM_WEIGHTS-1 issues, mem_addr wraps to 0 and FETCH continues, done pulses per completed pass, and DRAIN is entered only at a pass end with loop low.
REQ-029 SHALL, without WEIGHT_STREAMER_LOOP_EN, omit the loop port and perform exactly one pass per start.

Structure
REQ-030 SHALL place the state encoding and default parameter constants in shared package conv_1x1_pkg.
REQ-031 SHALL implement the credit counter as sub-module conv_1x1_credit_counter (inputs inc, dec; outputs count, full).

Verification
REQ-032 SHALL cover: reset low then high, start with memory word = address+1, load_weights held high -> 64 valid_out carrying 1..64 in order, done on the 64th, busy low the next cycle.
REQ-033 SHALL cover: FIFO_DEPTH=16, no load_weights -> exactly 16 reads issued, then mem_rd_en stays 0; one load_weights pulse -> exactly one more read.
REQ-034 SHALL cover: load_weights on the same cycle as a read at credits=15 -> count stays 15, reads continue.
REQ-035 SHALL cover: reset low during read 20 -> all outputs 0 immediately; after release, no valid_out until a new start.
REQ-036 SHALL cover: start pulsed again mid-pass -> ignored, total valid_out count remains 64.
REQ-037 SHALL cover: with WEIGHT_STREAMER_LOOP_EN and loop high for two passes -> 128 words with mem_addr wrapping 63->0, done pulsed twice, then IDLE.

Source files
------------

// File: rtl/conv_1x1_pkg.sv
// Shared state encoding, default parameters and sizing helper for the 1x1 conv weight streamer.
package conv_1x1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_NUM_WEIGHTS = 64;
  localparam int DEF_ADDR_WIDTH  = 6;
  localparam int DEF_FIFO_DEPTH  = 16;

  // Counter width able to hold the full range 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/conv_1x1_credit_counter.sv
// Credit counter for the downstream weight buffer: saturates at DEPTH, never underflows.
module conv_1x1_credit_counter
  import conv_1x1_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int CW    = credit_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full
);

  logic inc_ok;
  logic dec_ok;

  assign full   = (count == CW'(DEPTH));
  assign inc_ok = inc && !full;
  assign dec_ok = dec && (count != '0);

  // Simultaneous inc and dec cancel; a dec at zero is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc_ok && !dec_ok) begin
      count <= count + 1'b1;
    end else if (dec_ok && !inc_ok) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/conv_1x1_weight_streamer.sv
// Streams NUM_WEIGHTS words from weight memory into a credit-limited buffer.
// Optional WEIGHT_STREAMER_LOOP_EN adds a loop input for back-to-back passes.
//
// state    | meaning
// ST_IDLE  | waiting for start; credits still track load_weights
// ST_FETCH | issuing reads 0..NUM_WEIGHTS-1 whenever credits allow
// ST_DRAIN | all reads issued; waiting for the last word to leave the pipe
module conv_1x1_weight_streamer
  import conv_1x1_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_WEIGHTS = DEF_NUM_WEIGHTS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
`ifdef WEIGHT_STREAMER_LOOP_EN
  input  logic                  loop,
`endif
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  valid_out,
  input  logic                  load_weights,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = credit_width(FIFO_DEPTH);

  state_t          state_q, state_d;
  logic [CW-1:0]   credit_count;
  logic            credit_full;
  logic            credit_dec;
  logic            last_rd;
  logic            loop_now;
  logic            rd_d1;
  logic            last_d1;

`ifdef WEIGHT_STREAMER_LOOP_EN
  assign loop_now = loop;
`else
  assign loop_now = 1'b0;
`endif

  assign mem_rd_en  = (state_q == ST_FETCH) && !credit_full;
  assign last_rd    = mem_rd_en && (mem_addr == ADDR_WIDTH'(NUM_WEIGHTS - 1));
  assign credit_dec = load_weights && (credit_count != '0);
  assign busy       = (state_q != ST_IDLE);

  conv_1x1_credit_counter #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_credit (
    .clk   (clk),
    .reset (reset),
    .inc   (mem_rd_en),
    .dec   (credit_dec),
    .count (credit_count),
    .full  (credit_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A done that coincides with another pass end still in the pipe is not the final one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (last_rd && !loop_now) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (done && !last_d1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr <= '0;
    end else if (mem_rd_en) begin
      mem_addr <= last_rd ? '0 : mem_addr + 1'b1;
    end
  end

  // Read strobe and pass-end marker travel two stages alongside the data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_d1     <= 1'b0;
      last_d1   <= 1'b0;
      valid_out <= 1'b0;
      done      <= 1'b0;
      out       <= '0;
    end else begin
      rd_d1     <= mem_rd_en;
      last_d1   <= last_rd;
      valid_out <= rd_d1;
      done      <= last_d1;
      if (rd_d1) out <= mem_data;
    end
  end

endmodule
